pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ext_int, input, 1, asynchronous external interrupt request, level.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each, ID-stage source registers.
REQ-005 SHALL have ports ex_rd (input, 5) and ex_mem_read (input, 1), EX-stage destination and load flag.
REQ-006 SHALL have ports ex_branch_taken (input, 1) and ex_mret (input, 1), EX-stage redirect and return-from-interrupt.
REQ-007 SHALL have port ex_pc, input, 32, EX-stage instruction PC.
REQ-008 SHALL have ports pc_stall, if_id_stall, if_id_flush, id_flush_hazard and id_flush_branch, output, 1 each, pipeline-register controls.
REQ-009 SHALL have ports int_detected and int_restore, output, 1 each, single-cycle ID/EX save and restore pulses.
REQ-010 SHALL have ports npc_sel (output, 2; 00 normal, 01 vector, 10 epc) and epc (output, 32).
REQ-011 SHALL have ports int_active (output, 1) and int_count (output, 8).

Function
REQ-012 SHALL detect load-use when ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2, combinationally.
REQ-013 SHALL, on load-use with ex_branch_taken=0, assert pc_stall, if_id_stall and id_flush_hazard in the same cycle.
REQ-014 SHALL, on ex_branch_taken=1, assert id_flush_branch and if_id_flush, and suppress all load-use outputs.
REQ-015 SHALL synchronise ext_int through two flops, then set a pending flag on a synchronised rising edge.
REQ-016 SHALL implement FSM states IDLE, DRAIN, ENTER, HANDLER and RETURN.
REQ-017 SHALL, in IDLE, go to DRAIN when pending=1, ex_branch_taken=0 and no load-use; otherwise remain in IDLE.
REQ-018 SHALL, in DRAIN, hold pc_stall=1 and if_id_stall=1 for exactly 2 cycles using a 2-bit down-counter, then go to ENTER.
REQ-019 SHALL, in ENTER (1 cycle), do all of the following:
- pulse int_detected;
- drive npc_sel=01;
- register epc<=ex_pc;
- clear pending;
- increment int_count, modulo 256 with wrap 255->0;
- go to HANDLER.
REQ-020 SHALL hold int_active=1 in HANDLER, and in RETURN on the transition cycle.
REQ-021 SHALL latch ext_int edges in HANDLER as pending without entering, since nesting is not supported.
REQ-022 SHALL go from HANDLER to RETURN on ex_mret=1.
REQ-023 SHALL, in RETURN (1 cycle), pulse int_restore, drive npc_sel=10, then go to IDLE.
REQ-024 SHALL, if pending is still set on return to IDLE, re-enter through DRAIN no earlier than the next cycle.
REQ-025 SHALL drive npc_sel=00 in every state and cycle not covered by REQ-019 or REQ-023.
REQ-026 SHALL keep ex_branch_taken flush outputs active in every state.
REQ-027 SHALL apply no other stall or flush in ENTER and RETURN.

Reset
REQ-028 SHALL, on reset assertion and regardless of clk, force:
- FSM=IDLE, pending=0, sync flops=0, drain counter=0;
- epc=0, int_count=0;
- all 1-bit outputs=0, npc_sel=00.
REQ-029 SHALL abandon any in-flight DRAIN, ENTER, HANDLER or RETURN sequence on reset, with no pulse emitted.

Structure
REQ-030 SHALL place the FSM state encoding, the npc_sel encodings and the drain length constant (2) in the shared CPU package.
REQ-031 SHALL isolate the load-use comparator as sub-module hazard_detect.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, no branch -> pc_stall=if_id_stall=id_flush_hazard=1 for 1 cycle; ex_rd=0 -> all 0.
REQ-033 Branch during load-use: ex_branch_taken=1 with REQ-032 inputs -> id_flush_branch=if_id_flush=1, id_flush_hazard=0, pc_stall=0.
REQ-034 Interrupt entry: ext_int rises at cycle 0, ex_pc=0x00000040 in ENTER -> all of the following:
- int_detected pulses at cycle 5 (2 sync + 1 IDLE + 2 DRAIN);
- npc_sel=01 that cycle;
- epc=0x00000040;
- int_count=1.
REQ-035 Return: ex_mret=1 in HANDLER -> next cycle int_restore=1 and npc_sel=10, then IDLE with int_active=0.
REQ-036 Deferred interrupt: ext_int edge in HANDLER -> no int_detected until after RETURN, then exactly one entry; with int_count=255, that entry wraps int_count to 0.
REQ-037 Reset mid-DRAIN: reset asserted at drain cycle 1 -> FSM=IDLE and all outputs 0 immediately; no int_detected after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: interrupt FSM states, next-PC
// select encodings and the drain length used before interrupt entry.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ENTER   = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } fsm_state_t;

    localparam logic [1:0] NPC_NORMAL = 2'b00;
    localparam logic [1:0] NPC_VECTOR = 2'b01;
    localparam logic [1:0] NPC_EPC    = 2'b10;

    localparam int unsigned DRAIN_LEN  = 2;
    // Down-counter preload: DRAIN lasts while the counter walks to zero.
    localparam logic [1:0]  DRAIN_LOAD = 2'(DRAIN_LEN - 1);

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the EX-stage load writes a register the ID stage reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic [4:0] src [2];
    logic [1:0] src_hit;

    assign src[0] = id_rs1;
    assign src[1] = id_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = reg_match(ex_rd, src[gi]);
        end
    endgenerate

    assign load_use = ex_mem_read && (src_hit != 2'b00);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush control plus a non-nesting external-interrupt
// sequencer (drain, enter, handler, return).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_int,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_mret,
    input  logic [31:0] ex_pc,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_flush_hazard,
    output logic        id_flush_branch,
    output logic        int_detected,
    output logic        int_restore,
    output logic [1:0]  npc_sel,
    output logic [31:0] epc,
    output logic        int_active,
    output logic [7:0]  int_count
);

    fsm_state_t  state_reg;
    logic [1:0]  sync_reg;
    logic        pending_reg;
    logic [1:0]  drain_cnt_reg;
    logic        drain_stall_reg;
    logic        int_detected_reg;
    logic        int_restore_reg;
    logic [1:0]  npc_sel_reg;
    logic [31:0] epc_reg;
    logic        int_active_reg;
    logic [7:0]  int_count_reg;

    logic load_use;
    logic int_rise;
    logic fsm_quiet;
    logic hazard_active;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Edge taken between the two synchroniser stages so a request is
    // pending two cycles after ext_int rises.
    assign int_rise = sync_reg[0] & ~sync_reg[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            sync_reg         <= 2'b00;
            pending_reg      <= 1'b0;
            drain_cnt_reg    <= 2'd0;
            drain_stall_reg  <= 1'b0;
            int_detected_reg <= 1'b0;
            int_restore_reg  <= 1'b0;
            npc_sel_reg      <= NPC_NORMAL;
            epc_reg          <= 32'd0;
            int_active_reg   <= 1'b0;
            int_count_reg    <= 8'd0;
        end else begin
            sync_reg         <= {sync_reg[0], ext_int};
            int_detected_reg <= 1'b0;
            int_restore_reg  <= 1'b0;
            npc_sel_reg      <= NPC_NORMAL;
            if (int_rise) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pending_reg && !ex_branch_taken && !load_use) begin
                        state_reg       <= ST_DRAIN;
                        drain_cnt_reg   <= DRAIN_LOAD;
                        drain_stall_reg <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == 2'd0) begin
                        state_reg        <= ST_ENTER;
                        drain_stall_reg  <= 1'b0;
                        int_detected_reg <= 1'b1;
                        npc_sel_reg      <= NPC_VECTOR;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 2'd1;
                    end
                end
                ST_ENTER: begin
                    epc_reg        <= ex_pc;
                    int_count_reg  <= int_count_reg + 8'd1;
                    int_active_reg <= 1'b1;
                    state_reg      <= ST_HANDLER;
                    // A fresh edge arriving this very cycle must not be lost.
                    if (!int_rise) begin
                        pending_reg <= 1'b0;
                    end
                end
                ST_HANDLER: begin
                    if (ex_mret) begin
                        state_reg       <= ST_RETURN;
                        int_restore_reg <= 1'b1;
                        npc_sel_reg     <= NPC_EPC;
                    end
                end
                ST_RETURN: begin
                    state_reg      <= ST_IDLE;
                    int_active_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_quiet     = (state_reg == ST_ENTER) || (state_reg == ST_RETURN);
    assign hazard_active = load_use && !ex_branch_taken && !fsm_quiet;

    // Combinational controls are forced low while reset is held.
    assign pc_stall        = !reset && (hazard_active || drain_stall_reg);
    assign if_id_stall     = !reset && (hazard_active || drain_stall_reg);
    assign id_flush_hazard = !reset && hazard_active;
    assign id_flush_branch = !reset && ex_branch_taken;
    assign if_id_flush     = !reset && ex_branch_taken;

    assign int_detected = int_detected_reg;
    assign int_restore  = int_restore_reg;
    assign npc_sel      = npc_sel_reg;
    assign epc          = epc_reg;
    assign int_active   = int_active_reg;
    assign int_count    = int_count_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: hazard controls and interrupt sequencing.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_int;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, ex_mret;
    logic [31:0] ex_pc;
    logic        pc_stall, if_id_stall, if_id_flush, id_flush_hazard, id_flush_branch;
    logic        int_detected, int_restore, int_active;
    logic [1:0]  npc_sel;
    logic [31:0] epc;
    logic [7:0]  int_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] epc;
        logic [7:0]  cnt;
    } ent_t;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic [4:0] exp;
    } lu_t;

    logic [4:0] ctl_q [$];
    ent_t       ent_q [$];
    logic [7:0] exp_count;
    logic [4:0] ctl;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_flush_hazard, id_flush_branch};

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ext_int         (ext_int),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mret         (ex_mret),
        .ex_pc           (ex_pc),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_flush_hazard (id_flush_hazard),
        .id_flush_branch (id_flush_branch),
        .int_detected    (int_detected),
        .int_restore     (int_restore),
        .npc_sel         (npc_sel),
        .epc             (epc),
        .int_active      (int_active),
        .int_count       (int_count)
    );

    // Returns the 1-based cycle index of the first int_detected pulse, or -1.
    task automatic wait_detect(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (int_detected === 1'b1) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        #3;
        checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL reset_ctl got=%b exp=00000", ctl); end
        checks++; if ({int_detected, int_restore, int_active} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {int_detected, int_restore, int_active}); end
        checks++; if (npc_sel !== 2'b00) begin failures++; $display("FAIL reset_npc got=%b exp=00", npc_sel); end
        checks++; if (epc !== 32'd0 || int_count !== 8'd0) begin failures++; $display("FAIL reset_epc_cnt got=%h/%0d exp=0/0", epc, int_count); end
        @(negedge clk);
        ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs2 = 5'd0;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({ctl, int_detected, npc_sel} !== 8'd0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", {ctl, int_detected, npc_sel}); end
        $display("reset: ctl=%b npc=%b epc=%h cnt=%0d", ctl, npc_sel, epc, int_count);
        exp_count = 8'd0;
    endtask

    task automatic test_load_use();
        lu_t        tab [8];
        logic [4:0] exp, got;
        tab[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 5'b11010};
        tab[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 5'b00000};
        tab[2] = '{1'b1, 5'd7,  5'd7,  5'd3,  1'b0, 5'b11010};
        tab[3] = '{1'b0, 5'd7,  5'd7,  5'd7,  1'b0, 5'b00000};
        tab[4] = '{1'b1, 5'd5,  5'd4,  5'd6,  1'b0, 5'b00000};
        tab[5] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b1, 5'b00101};
        tab[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'b00101};
        tab[7] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 5'b11010};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ex_mem_read = tab[i].mr; ex_rd = tab[i].rd; id_rs1 = tab[i].rs1;
            id_rs2 = tab[i].rs2; ex_branch_taken = tab[i].br;
            ctl_q.push_back(tab[i].exp);
            #2;
            got = ctl;
            exp = ctl_q.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, exp); end
            $display("load_use[%0d]: ctl=%b", i, got);
        end
        @(negedge clk);
        ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic test_int_entry();
        int   k;
        ent_t e;
        @(negedge clk);
        ex_pc = 32'h0000_0040; ext_int = 1'b1;
        exp_count = exp_count + 8'd1;
        ent_q.push_back('{32'h0000_0040, exp_count});
        wait_detect(12, k);
        checks++; if (k !== 5) begin failures++; $display("FAIL entry_cycle got=%0d exp=5", k); end
        checks++; if (npc_sel !== 2'b01) begin failures++; $display("FAIL entry_npc got=%b exp=01", npc_sel); end
        checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL entry_no_stall got=%b exp=00000", ctl); end
        @(posedge clk); #1;
        e = ent_q.pop_front();
        checks++; if (epc !== e.epc) begin failures++; $display("FAIL entry_epc got=%h exp=%h", epc, e.epc); end
        checks++; if (int_count !== e.cnt) begin failures++; $display("FAIL entry_count got=%0d exp=%0d", int_count, e.cnt); end
        checks++; if (int_active !== 1'b1 || int_detected !== 1'b0) begin failures++; $display("FAIL entry_handler got=%b%b exp=10", int_active, int_detected); end
        $display("int_entry: cycle=%0d epc=%h cnt=%0d", k, epc, int_count);
    endtask

    task automatic test_return();
        @(negedge clk);
        ext_int = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (int_active !== 1'b1 || npc_sel !== 2'b00) begin failures++; $display("FAIL handler_hold got=%b/%b exp=1/00", int_active, npc_sel); end
        ex_mret = 1'b1;
        @(posedge clk); #1;
        checks++; if (int_restore !== 1'b1 || npc_sel !== 2'b10) begin failures++; $display("FAIL return_pulse got=%b/%b exp=1/10", int_restore, npc_sel); end
        checks++; if (int_active !== 1'b1) begin failures++; $display("FAIL return_active got=%b exp=1", int_active); end
        @(negedge clk);
        ex_mret = 1'b0;
        @(posedge clk); #1;
        checks++; if ({int_restore, npc_sel, int_active} !== 4'b0000) begin failures++; $display("FAIL return_idle got=%b exp=0000", {int_restore, npc_sel, int_active}); end
        $display("return: restore=%b npc=%b active=%b", int_restore, npc_sel, int_active);
    endtask

    task automatic test_back_to_back();
        int   k;
        ent_t e;
        for (int n = 0; n < 253; n++) begin
            @(negedge clk);
            ex_pc = $urandom; ext_int = 1'b1;
            exp_count = exp_count + 8'd1;
            ent_q.push_back('{ex_pc, exp_count});
            wait_detect(12, k);
            checks++; if (k !== 5 || npc_sel !== 2'b01) begin failures++; $display("FAIL b2b_entry[%0d] got=%0d/%b exp=5/01", n, k, npc_sel); end
            @(posedge clk); #1;
            e = ent_q.pop_front();
            checks++; if (epc !== e.epc) begin failures++; $display("FAIL b2b_epc[%0d] got=%h exp=%h", n, epc, e.epc); end
            checks++; if (int_count !== e.cnt) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", n, int_count, e.cnt); end
            $display("b2b[%0d]: epc=%h cnt=%0d", n, epc, int_count);
            @(negedge clk); ext_int = 1'b0; ex_mret = 1'b1;
            @(negedge clk); ex_mret = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_deferred_wrap();
        int   k;
        ent_t e;
        @(negedge clk);
        ex_pc = 32'h1234_5678; ext_int = 1'b1;
        exp_count = exp_count + 8'd1;
        ent_q.push_back('{ex_pc, exp_count});
        wait_detect(12, k);
        checks++; if (k !== 5) begin failures++; $display("FAIL defer_first_cycle got=%0d exp=5", k); end
        @(posedge clk); #1;
        e = ent_q.pop_front();
        checks++; if (int_count !== e.cnt || epc !== e.epc) begin failures++; $display("FAIL defer_first got=%0d/%h exp=%0d/%h", int_count, epc, e.cnt, e.epc); end
        @(negedge clk); ext_int = 1'b0;
        repeat (3) @(negedge clk);
        ext_int = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (int_detected !== 1'b0 || int_active !== 1'b1) begin failures++; $display("FAIL defer_nested[%0d] got=%b%b exp=01", i, int_detected, int_active); end
        end
        @(negedge clk);
        ex_mret = 1'b1; ex_pc = 32'hCAFE_0100;
        exp_count = exp_count + 8'd1;
        ent_q.push_back('{ex_pc, exp_count});
        @(posedge clk); #1;
        checks++; if (int_restore !== 1'b1 || int_detected !== 1'b0) begin failures++; $display("FAIL defer_return got=%b%b exp=10", int_restore, int_detected); end
        @(negedge clk); ex_mret = 1'b0;
        wait_detect(12, k);
        checks++; if (k !== 4) begin failures++; $display("FAIL defer_reentry_cycle got=%0d exp=4", k); end
        @(posedge clk); #1;
        e = ent_q.pop_front();
        checks++; if (int_count !== e.cnt) begin failures++; $display("FAIL defer_wrap_count got=%0d exp=%0d", int_count, e.cnt); end
        checks++; if (epc !== e.epc) begin failures++; $display("FAIL defer_epc got=%h exp=%h", epc, e.epc); end
        $display("deferred: reentry=%0d cnt=%0d epc=%h", k, int_count, epc);
        @(negedge clk); ext_int = 1'b0; ex_mret = 1'b1;
        @(negedge clk); ex_mret = 1'b0;
        wait_detect(10, k);
        checks++; if (k !== -1) begin failures++; $display("FAIL defer_single_entry got=%0d exp=-1", k); end
    endtask

    task automatic test_reset_mid_drain();
        int k;
        @(negedge clk);
        ext_int = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ctl !== 5'b11000) begin failures++; $display("FAIL drain_stall got=%b exp=11000", ctl); end
        #2;
        reset = 1'b1;
        #1;
        exp_count = 8'd0;
        checks++; if ({ctl, int_detected, int_restore, int_active, npc_sel} !== 10'd0) begin failures++; $display("FAIL mid_drain_outputs got=%b exp=0", {ctl, int_detected, int_restore, int_active, npc_sel}); end
        checks++; if (int_count !== exp_count || epc !== 32'd0) begin failures++; $display("FAIL mid_drain_regs got=%0d/%h exp=0/0", int_count, epc); end
        ext_int = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_detect(15, k);
        checks++; if (k !== -1) begin failures++; $display("FAIL mid_drain_no_entry got=%0d exp=-1", k); end
        checks++; if (int_count !== exp_count) begin failures++; $display("FAIL mid_drain_count got=%0d exp=%0d", int_count, exp_count); end
        $display("reset_mid_drain: detect=%0d cnt=%0d", k, int_count);
    endtask

    initial begin
        reset = 1'b1; ext_int = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mret = 1'b0;
        ex_pc = 32'd0; exp_count = 8'd0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_int_entry();
        test_return();
        test_back_to_back();
        test_deferred_wrap();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
